// File: rtl/ctrl_ext_ex_mem_pkg.sv
// mips_pkg: opcode/funct encodings, ALU codes and control encodings shared by decode and EX/MEM.
// Pure definitions plus the immediate-extension helper; no state, no handshake.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_NOR   = 5'd5;
  localparam logic [4:0] ALU_SLT   = 5'd6;
  localparam logic [4:0] ALU_SLTU  = 5'd7;
  localparam logic [4:0] ALU_SLL   = 5'd8;
  localparam logic [4:0] ALU_SRL   = 5'd9;
  localparam logic [4:0] ALU_SRA   = 5'd10;
  localparam logic [4:0] ALU_PASSB = 5'd11;

  localparam logic [1:0] EXT_ZERO     = 2'b00;
  localparam logic [1:0] EXT_SIGN     = 2'b01;
  localparam logic [1:0] EXT_LUI      = 2'b10;
  localparam logic [1:0] EXT_ZERO_ALT = 2'b11;

  localparam logic [1:0] BR_NONE   = 2'b00;
  localparam logic [1:0] BR_BEQ    = 2'b01;
  localparam logic [1:0] BR_BNE    = 2'b10;
  localparam logic [1:0] BR_UNCOND = 2'b11;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;
  localparam logic [1:0] JMP_JAL  = 2'b10;
  localparam logic [1:0] JMP_JR   = 2'b11;

  function automatic logic [31:0] ext_imm(input logic [1:0] op, input logic [15:0] imm);
    logic [31:0] r;
    case (op)
      EXT_SIGN:     r = {{16{imm[15]}}, imm};
      EXT_LUI:      r = {imm, 16'h0000};
      EXT_ZERO,
      EXT_ZERO_ALT: r = {16'h0000, imm};
      default:      r = {16'h0000, imm};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_ext_ex_mem_if.sv
// EX/MEM bus: EX-stage results and memory-stage controls in, registered copies out.
// master drives *_IN/EX_MEM_WR (flush too when EXMEM_FLUSH_EN); slave is the register.
interface ctrl_ext_ex_mem_if;
  logic        EX_MEM_WR;
  logic [31:0] NPC_IN;
  logic [31:0] NPC_OUT;
  logic [31:0] ALU_C_IN;
  logic [31:0] ALU_C_OUT;
  logic [31:0] RT_DATA_IN;
  logic [31:0] RT_DATA_OUT;
  logic        ZERO_IN;
  logic        ZERO_OUT;
  logic [1:0]  jump_in;
  logic [1:0]  jump_out;
  logic [1:0]  Branch_IN;
  logic [1:0]  Branch_OUT;
  logic [4:0]  reg_rd_in;
  logic [4:0]  reg_rd_out;
  logic        MEMR_IN;
  logic        MEMR_OUT;
  logic        MEMW_IN;
  logic        MEMW_OUT;
  logic        REGW_IN;
  logic        REGW_OUT;
  logic        MEM2R_IN;
  logic        MEM2R_OUT;
`ifdef EXMEM_FLUSH_EN
  logic        flush;
`endif

  modport master (
    output EX_MEM_WR, NPC_IN, ALU_C_IN, RT_DATA_IN, ZERO_IN, jump_in, Branch_IN,
           reg_rd_in, MEMR_IN, MEMW_IN, REGW_IN, MEM2R_IN,
`ifdef EXMEM_FLUSH_EN
           flush,
`endif
    input  NPC_OUT, ALU_C_OUT, RT_DATA_OUT, ZERO_OUT, jump_out, Branch_OUT,
           reg_rd_out, MEMR_OUT, MEMW_OUT, REGW_OUT, MEM2R_OUT
  );

  modport slave (
    input  EX_MEM_WR, NPC_IN, ALU_C_IN, RT_DATA_IN, ZERO_IN, jump_in, Branch_IN,
           reg_rd_in, MEMR_IN, MEMW_IN, REGW_IN, MEM2R_IN,
`ifdef EXMEM_FLUSH_EN
           flush,
`endif
    output NPC_OUT, ALU_C_OUT, RT_DATA_OUT, ZERO_OUT, jump_out, Branch_OUT,
           reg_rd_out, MEMR_OUT, MEMW_OUT, REGW_OUT, MEM2R_OUT
  );
endinterface

// File: rtl/ctrl_ext_ex_mem_exmem_stage_reg.sv
// exmem_stage_reg: EX/MEM pipeline register, 1-cycle latency, loads on EX_MEM_WR else holds.
// Sync active-high rst wins over everything; EXMEM_FLUSH_EN adds flush that zeroes control fields.
module exmem_stage_reg (
  input  logic clk,
  input  logic rst,
  ctrl_ext_ex_mem_if.slave bus
);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.NPC_OUT     <= '0;
      bus.ALU_C_OUT   <= '0;
      bus.RT_DATA_OUT <= '0;
      bus.ZERO_OUT    <= 1'b0;
      bus.reg_rd_out  <= '0;
    end else if (bus.EX_MEM_WR) begin
      bus.NPC_OUT     <= bus.NPC_IN;
      bus.ALU_C_OUT   <= bus.ALU_C_IN;
      bus.RT_DATA_OUT <= bus.RT_DATA_IN;
      bus.ZERO_OUT    <= bus.ZERO_IN;
      bus.reg_rd_out  <= bus.reg_rd_in;
    end
  end

  // Control fields kept separate so a flush can squash them without touching the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.jump_out   <= '0;
      bus.Branch_OUT <= '0;
      bus.MEMR_OUT   <= 1'b0;
      bus.MEMW_OUT   <= 1'b0;
      bus.REGW_OUT   <= 1'b0;
      bus.MEM2R_OUT  <= 1'b0;
`ifdef EXMEM_FLUSH_EN
    end else if (bus.flush) begin
      bus.jump_out   <= '0;
      bus.Branch_OUT <= '0;
      bus.MEMR_OUT   <= 1'b0;
      bus.MEMW_OUT   <= 1'b0;
      bus.REGW_OUT   <= 1'b0;
      bus.MEM2R_OUT  <= 1'b0;
`endif
    end else if (bus.EX_MEM_WR) begin
      bus.jump_out   <= bus.jump_in;
      bus.Branch_OUT <= bus.Branch_IN;
      bus.MEMR_OUT   <= bus.MEMR_IN;
      bus.MEMW_OUT   <= bus.MEMW_IN;
      bus.REGW_OUT   <= bus.REGW_IN;
      bus.MEM2R_OUT  <= bus.MEM2R_IN;
    end
  end

endmodule

// File: rtl/ctrl_ext_ex_mem.sv
// ctrl_ext_ex_mem: combinational main decoder + immediate extender (zero latency) and EX/MEM register.
// Register has 1-cycle latency and holds when EX_MEM_WR=0; EXMEM_FLUSH_EN enables the flush input.
module ctrl_ext_ex_mem
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  Funct,
  input  logic [15:0] Imm16,
  output logic [1:0]  jump,
  output logic        RegDst,
  output logic [1:0]  Branch,
  output logic        MemR,
  output logic        Mem2R,
  output logic        MemW,
  output logic        RegW,
  output logic        Alusrc,
  output logic [1:0]  EXTOp,
  output logic [4:0]  Aluctrl,
  output logic [31:0] Imm32,
  ctrl_ext_ex_mem_if.slave exmem
);

  always_comb begin
    jump    = JMP_NONE;
    RegDst  = 1'b0;
    Branch  = BR_NONE;
    MemR    = 1'b0;
    Mem2R   = 1'b0;
    MemW    = 1'b0;
    RegW    = 1'b0;
    Alusrc  = 1'b0;
    EXTOp   = EXT_ZERO;
    Aluctrl = ALU_ADD;
    case (OpCode)
      OP_RTYPE: begin
        // Unrecognised funct must fall through as a full NOP, so RegW is set per entry.
        case (Funct)
          F_ADD, F_ADDU: begin RegW = 1'b1; Aluctrl = ALU_ADD;  end
          F_SUB, F_SUBU: begin RegW = 1'b1; Aluctrl = ALU_SUB;  end
          F_AND:         begin RegW = 1'b1; Aluctrl = ALU_AND;  end
          F_OR:          begin RegW = 1'b1; Aluctrl = ALU_OR;   end
          F_XOR:         begin RegW = 1'b1; Aluctrl = ALU_XOR;  end
          F_NOR:         begin RegW = 1'b1; Aluctrl = ALU_NOR;  end
          F_SLT:         begin RegW = 1'b1; Aluctrl = ALU_SLT;  end
          F_SLTU:        begin RegW = 1'b1; Aluctrl = ALU_SLTU; end
          F_SLL:         begin RegW = 1'b1; Aluctrl = ALU_SLL;  end
          F_SRL:         begin RegW = 1'b1; Aluctrl = ALU_SRL;  end
          F_SRA:         begin RegW = 1'b1; Aluctrl = ALU_SRA;  end
          F_JR:          jump = JMP_JR;
          default:       ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        Alusrc = 1'b1;
        RegDst = 1'b1;
        RegW   = 1'b1;
        case (OpCode)
          OP_ADDI, OP_ADDIU: begin Aluctrl = ALU_ADD;   EXTOp = EXT_SIGN; end
          OP_SLTI:           begin Aluctrl = ALU_SLT;   EXTOp = EXT_SIGN; end
          OP_SLTIU:          begin Aluctrl = ALU_SLTU;  EXTOp = EXT_SIGN; end
          OP_ANDI:           begin Aluctrl = ALU_AND;   EXTOp = EXT_ZERO; end
          OP_ORI:            begin Aluctrl = ALU_OR;    EXTOp = EXT_ZERO; end
          OP_XORI:           begin Aluctrl = ALU_XOR;   EXTOp = EXT_ZERO; end
          default:           begin Aluctrl = ALU_PASSB; EXTOp = EXT_LUI;  end
        endcase
      end
      OP_LW: begin
        MemR    = 1'b1;
        Mem2R   = 1'b1;
        RegW    = 1'b1;
        Alusrc  = 1'b1;
        RegDst  = 1'b1;
        EXTOp   = EXT_SIGN;
        Aluctrl = ALU_ADD;
      end
      OP_SW: begin
        MemW    = 1'b1;
        Alusrc  = 1'b1;
        EXTOp   = EXT_SIGN;
        Aluctrl = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        Branch  = (OpCode == OP_BEQ) ? BR_BEQ : BR_BNE;
        Aluctrl = ALU_SUB;
        EXTOp   = EXT_SIGN;
      end
      // jal's link write is handled elsewhere in the core, so RegW stays low here.
      OP_J, OP_JAL: begin
        Branch = BR_UNCOND;
        jump   = (OpCode == OP_J) ? JMP_J : JMP_JAL;
      end
      default: ;
    endcase
  end

  assign Imm32 = ext_imm(EXTOp, Imm16);

  exmem_stage_reg u_exmem (
    .clk (clk),
    .rst (rst),
    .bus (exmem)
  );

endmodule

// File: tb/tb_ctrl_ext_ex_mem.sv
// Random + directed bench for ctrl_ext_ex_mem: decoder/extender/EX-MEM register vs. a table-driven model.
// Honors EXMEM_FLUSH_EN when defined.
module tb_ctrl_ext_ex_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  opcode, funct;
  logic [15:0] imm16;
  logic [1:0]  jump, branch, extop;
  logic        regdst, memr, mem2r, memw, regw, alusrc;
  logic [4:0]  aluctrl;
  logic [31:0] imm32;

  ctrl_ext_ex_mem_if bus();

  ctrl_ext_ex_mem dut (
    .clk(clk), .rst(rst), .OpCode(opcode), .Funct(funct), .Imm16(imm16),
    .jump(jump), .RegDst(regdst), .Branch(branch), .MemR(memr), .Mem2R(mem2r),
    .MemW(memw), .RegW(regw), .Alusrc(alusrc), .EXTOp(extop), .Aluctrl(aluctrl),
    .Imm32(imm32), .exmem(bus)
  );

  typedef struct packed {
    logic [1:0] jump; logic regdst; logic [1:0] branch;
    logic memr, mem2r, memw, regw, alusrc;
    logic [1:0] extop; logic [4:0] aluctrl;
  } dec_t;

  typedef struct packed {
    logic [31:0] npc, aluc, rtd; logic zero;
    logic [1:0] jump, branch; logic [4:0] rd;
    logic memr, memw, regw, mem2r;
  } reg_t;

  int n_checks = 0;
  int n_fail   = 0;
  int rtab [64];
  int itab [8] = '{0, 0, 6, 7, 2, 3, 4, 11};
  logic [5:0] vops [15] = '{6'd0, 6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9,
                            6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15};
  logic [5:0] vfns [15] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
                            6'd42, 6'd43, 6'd0, 6'd2, 6'd3, 6'd8, 6'd8};
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decoder rules: R-type via funct table, immediate group via opcode[2:0] table.
  function automatic dec_t dec_model(input logic [5:0] op, input logic [5:0] fn);
    dec_t d = '0;
    if (op == 6'd0) begin
      if (fn == 6'd8) d.jump = 2'd3;
      else if (rtab[fn] >= 0) begin d.regw = 1'b1; d.aluctrl = 5'(rtab[fn]); end
    end else if (op[5:3] == 3'b001) begin
      d.alusrc = 1'b1; d.regdst = 1'b1; d.regw = 1'b1;
      d.aluctrl = 5'(itab[op[2:0]]);
      d.extop = (op[2:0] == 3'd7) ? 2'd2 : (op[2] ? 2'd0 : 2'd1);
    end else if (op == 6'd35) begin
      d.memr = 1'b1; d.mem2r = 1'b1; d.regw = 1'b1; d.alusrc = 1'b1; d.regdst = 1'b1; d.extop = 2'd1;
    end else if (op == 6'd43) begin
      d.memw = 1'b1; d.alusrc = 1'b1; d.extop = 2'd1;
    end else if (op == 6'd4 || op == 6'd5) begin
      d.branch = op[0] ? 2'd2 : 2'd1; d.aluctrl = 5'd1; d.extop = 2'd1;
    end else if (op == 6'd2 || op == 6'd3) begin
      d.branch = 2'd3; d.jump = op[0] ? 2'd2 : 2'd1;
    end
    return d;
  endfunction

  function automatic logic [31:0] ext_model(input logic [1:0] e, input logic [15:0] imm);
    logic [31:0] z = {16'h0, imm};
    if (e == 2'd1) return imm[15] ? 32'hFFFF0000 + z : z;
    if (e == 2'd2) return z * 32'd65536;
    return z;
  endfunction

  dec_t act_dec;
  reg_t act_reg, in_reg, exp_reg;
  assign act_dec = {jump, regdst, branch, memr, mem2r, memw, regw, alusrc, extop, aluctrl};
  assign act_reg = {bus.NPC_OUT, bus.ALU_C_OUT, bus.RT_DATA_OUT, bus.ZERO_OUT, bus.jump_out,
                    bus.Branch_OUT, bus.reg_rd_out, bus.MEMR_OUT, bus.MEMW_OUT, bus.REGW_OUT,
                    bus.MEM2R_OUT};
  assign in_reg  = {bus.NPC_IN, bus.ALU_C_IN, bus.RT_DATA_IN, bus.ZERO_IN, bus.jump_in,
                    bus.Branch_IN, bus.reg_rd_in, bus.MEMR_IN, bus.MEMW_IN, bus.REGW_IN,
                    bus.MEM2R_IN};

  always @(posedge clk) begin
    reg_t nxt;
    nxt = exp_reg;
    if (rst) nxt = '0;
    else begin
      if (bus.EX_MEM_WR) nxt = in_reg;
`ifdef EXMEM_FLUSH_EN
      if (bus.flush) begin
        nxt.jump = '0; nxt.branch = '0;
        nxt.memr = 1'b0; nxt.memw = 1'b0; nxt.regw = 1'b0; nxt.mem2r = 1'b0;
      end
`endif
    end
    exp_reg <= nxt;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      dec_t d;
      d = dec_model(opcode, funct);
      check("decode", 128'(act_dec), 128'(d));
      check("imm32", 128'(imm32), 128'(ext_model(d.extop, imm16)));
      check("exmem", 128'(act_reg), 128'(exp_reg));
    end
  end

  task automatic set_dec(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] imm);
    opcode = op; funct = fn; imm16 = imm;
    @(negedge clk);
  endtask

  task automatic edge_then_settle();
    @(posedge clk); #1;
  endtask

  initial begin
    foreach (rtab[i]) rtab[i] = -1;
    rtab[32] = 0; rtab[33] = 0; rtab[34] = 1; rtab[35] = 1; rtab[36] = 2; rtab[37] = 3;
    rtab[38] = 4; rtab[39] = 5; rtab[42] = 6; rtab[43] = 7; rtab[0] = 8; rtab[2] = 9; rtab[3] = 10;

    rst = 1'b1; opcode = '0; funct = '0; imm16 = '0;
    bus.EX_MEM_WR = 1'b1; bus.NPC_IN = 32'h1111; bus.ALU_C_IN = 32'h2222; bus.RT_DATA_IN = 32'h3333;
    bus.ZERO_IN = 1'b1; bus.jump_in = 2'd1; bus.Branch_IN = 2'd2; bus.reg_rd_in = 5'd7;
    bus.MEMR_IN = 1'b1; bus.MEMW_IN = 1'b1; bus.REGW_IN = 1'b1; bus.MEM2R_IN = 1'b1;
`ifdef EXMEM_FLUSH_EN
    bus.flush = 1'b0;
`endif
    edge_then_settle();
    edge_then_settle();
    rst = 1'b0; bus.EX_MEM_WR = 1'b0;
    @(negedge clk);
    check("reset_state", 128'(act_reg), 128'd0);
    cmp_en = 1'b1;

    set_dec(6'b100011, 6'd0, 16'h0004);
    check("lw_ctrl", 128'({memr, mem2r, regw, alusrc, regdst, extop, aluctrl, branch, jump}),
          128'({5'b11111, 2'b01, 5'd0, 2'b00, 2'b00}));
    set_dec(6'b000000, 6'b100010, 16'h0);
    check("sub_ctrl", 128'({regw, regdst, aluctrl}), 128'({1'b1, 1'b0, 5'd1}));
    set_dec(6'b000000, 6'b001000, 16'h0);
    check("jr_ctrl", 128'({jump, regw}), 128'({2'b11, 1'b0}));
    set_dec(6'b000000, 6'b111111, 16'h0);
    check("bad_funct", 128'(act_dec), 128'd0);
    set_dec(6'b001000, 6'd0, 16'h8001);
    check("imm_sign", 128'(imm32), 128'h0000_0000_0000_0000_0000_0000_FFFF_8001);
    set_dec(6'b001101, 6'd0, 16'h8001);
    check("imm_zero", 128'(imm32), 128'h0000_8001);
    set_dec(6'b001111, 6'd0, 16'h8001);
    check("imm_lui", 128'(imm32), 128'h8001_0000);
    set_dec(6'b000101, 6'd0, 16'h0);
    check("bne_ctrl", 128'({branch, aluctrl}), 128'({2'b10, 5'd1}));
    set_dec(6'b000011, 6'd0, 16'h0);
    check("jal_ctrl", 128'({branch, jump, regw}), 128'({2'b11, 2'b10, 1'b0}));
    set_dec(6'b111111, 6'd5, 16'h0);
    check("bad_op", 128'(act_dec), 128'd0);

    edge_then_settle();
    rst = 1'b1;
    edge_then_settle();
    rst = 1'b0; bus.EX_MEM_WR = 1'b1;
    bus.ALU_C_IN = 32'hDEADBEEF; bus.reg_rd_in = 5'd9; bus.REGW_IN = 1'b1;
    edge_then_settle();
    bus.EX_MEM_WR = 1'b0; bus.ALU_C_IN = 32'h0BAD0BAD; bus.reg_rd_in = 5'd3; bus.REGW_IN = 1'b0;
    @(negedge clk);
    check("load_vals", 128'({bus.ALU_C_OUT, bus.reg_rd_out, bus.REGW_OUT}),
          128'({32'hDEADBEEF, 5'd9, 1'b1}));
    edge_then_settle();
    @(negedge clk);
    check("hold_vals", 128'({bus.ALU_C_OUT, bus.reg_rd_out, bus.REGW_OUT}),
          128'({32'hDEADBEEF, 5'd9, 1'b1}));
    edge_then_settle();
    rst = 1'b1; bus.EX_MEM_WR = 1'b1;
    edge_then_settle();
    rst = 1'b0; bus.EX_MEM_WR = 1'b0;
    @(negedge clk);
    check("rst_priority", 128'(act_reg), 128'd0);
`ifdef EXMEM_FLUSH_EN
    edge_then_settle();
    bus.EX_MEM_WR = 1'b1; bus.flush = 1'b1; bus.ALU_C_IN = 32'h00001234;
    bus.REGW_IN = 1'b1; bus.MEMW_IN = 1'b1; bus.Branch_IN = 2'd2; bus.jump_in = 2'd1;
    edge_then_settle();
    bus.EX_MEM_WR = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("flush", 128'({bus.ALU_C_OUT, bus.REGW_OUT, bus.MEMW_OUT, bus.Branch_OUT, bus.jump_out}),
          128'({32'h00001234, 1'b0, 1'b0, 2'b00, 2'b00}));
`endif

    repeat (500) begin
      edge_then_settle();
      rst = ($urandom_range(0, 24) == 0);
      opcode = ($urandom_range(0, 9) < 8) ? vops[$urandom_range(0, 14)] : 6'($urandom);
      funct  = ($urandom_range(0, 9) < 8) ? vfns[$urandom_range(0, 14)] : 6'($urandom);
      imm16  = 16'($urandom);
      bus.EX_MEM_WR  = ($urandom_range(0, 2) != 0);
      bus.NPC_IN     = $urandom; bus.ALU_C_IN = $urandom; bus.RT_DATA_IN = $urandom;
      bus.ZERO_IN    = 1'($urandom); bus.jump_in = 2'($urandom); bus.Branch_IN = 2'($urandom);
      bus.reg_rd_in  = 5'($urandom);
      bus.MEMR_IN    = 1'($urandom); bus.MEMW_IN = 1'($urandom);
      bus.REGW_IN    = 1'($urandom); bus.MEM2R_IN = 1'($urandom);
`ifdef EXMEM_FLUSH_EN
      bus.flush      = ($urandom_range(0, 5) == 0);
`endif
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_ext_ex_mem.md
# ctrl_ext_ex_mem

Decode-and-latch block for the 5-stage MIPS core. It holds three independent functions: the combinational main decoder (opcode/funct to datapath controls), the immediate extender, and the EX/MEM pipeline register that carries execute-stage results into memory. The decoder and extender sit in ID. The register sits between the ALU and data memory.

## Interface
- Parameters: none. Widths are fixed by the ISA.
- Reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock, used only by the EX/MEM register
- rst  in  1  synchronous active-high reset
- OpCode  in  6  instr[31:26]
- Funct  in  6  instr[5:0]
- Imm16  in  16  instr[15:0]
- jump  out  2  00 none, 01 j, 10 jal, 11 jr
- RegDst  out  1  1 = write rt, 0 = write rd
- Branch  out  2  00 none, 01 beq, 10 bne, 11 unconditional (j/jal)
- MemR, Mem2R, MemW, RegW, Alusrc  out  1 each  load read, load-to-reg, store, reg write, ALU B = immediate
- EXTOp  out  2  00 zero, 01 sign, 10 lui (Imm16<<16), 11 zero
- Aluctrl  out  5  ALU operation code
- Imm32  out  32  extended immediate, driven by the internal EXTOp
- EX_MEM_WR  in  1  register load enable
- NPC_IN/NPC_OUT  in/out  32  branch target
- ALU_C_IN/ALU_C_OUT  in/out  32  ALU result
- RT_DATA_IN/RT_DATA_OUT  in/out  32  store data
- ZERO_IN/ZERO_OUT  in/out  1  ALU zero flag
- jump_in/jump_out  in/out  2  jump type
- Branch_IN/Branch_OUT  in/out  2  branch type
- reg_rd_in/reg_rd_out  in/out  5  destination register
- MEMR_IN/OUT, MEMW_IN/OUT, REGW_IN/OUT, MEM2R_IN/OUT  in/out  1 each  memory-stage controls

## Operation
- Aluctrl codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLTU 7, SLL 8, SRL 9, SRA 10, PASSB 11.
- R-type (OpCode 000000):
  - RegW=1, RegDst=0.
  - Funct map: add/addu (100000/100001) ADD; sub/subu (100010/100011) SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010 SLT; 101011 SLTU; 000000 SLL; 000010 SRL; 000011 SRA.
  - jr (001000): jump=11, RegW=0.
  - Any other funct: all outputs 0.
- Immediate ALU ops: Alusrc=1, RegDst=1, RegW=1.
  - addi/addiu (001000/001001) ADD, sign.
  - slti (001010) SLT, sign; sltiu (001011) SLTU, sign.
  - andi (001100) AND, zero; ori (001101) OR, zero; xori (001110) XOR, zero.
  - lui (001111): EXTOp=10, PASSB.
- lw (100011): MemR=Mem2R=RegW=Alusrc=RegDst=1, sign, ADD.
- sw (101011): MemW=Alusrc=1, sign, ADD, RegW=0.
- beq (000100) / bne (000101): Branch=01/10, SUB, sign, Alusrc=0.
- j (000010) / jal (000011): Branch=11, jump=01/10. RegW=0; the link write is not performed by this block.
- Unknown opcode: every decoder output is 0 (acts as NOP).
- Extender: zero gives {16'h0, Imm16}; sign gives {{16{Imm16[15]}}, Imm16}; lui gives {Imm16, 16'h0}; EXTOp=11 gives zero extension.
- EX/MEM register, on rising clk:
  - rst=1: all outputs clear to 0. rst has priority over EX_MEM_WR.
  - else EX_MEM_WR=1: every *_OUT loads its *_IN.
  - else: all outputs hold.

## Timing
- Decoder and extender are purely combinational, with no clock dependence and zero latency.
- EX/MEM register has 1-cycle latency: an input captured at edge N is visible after edge N until the next load.
- Every register output is 0 from the first reset edge. An asynchronous rst assertion has no effect until the next edge.
- Reset asserted mid-stream discards the in-flight EX/MEM contents at that edge.

## Configuration
- EXMEM_FLUSH_EN defined: adds input `flush` (1 bit).
  - On a clock edge with flush=1 (and rst=0), MEMR_OUT, MEMW_OUT, REGW_OUT, MEM2R_OUT, Branch_OUT and jump_out clear to 0. Data fields load normally if EX_MEM_WR=1.
  - flush takes priority over EX_MEM_WR for the control fields.
- EXMEM_FLUSH_EN undefined: the port does not exist and behaviour is exactly as in Operation.

## Structure
- Shared package `mips_pkg` holds:
  - opcode and funct localparams;
  - Aluctrl code constants;
  - EXTOp, Branch and jump encodings.
- The EX/MEM register is one natural sub-module, `exmem_stage_reg`. Decoder and extender are combinational always/assign logic in the top.

## Test plan
- OpCode 100011 -> MemR=Mem2R=RegW=Alusrc=RegDst=1, EXTOp=01, Aluctrl=0, Branch=00, jump=00.
- OpCode 000000, Funct 100010 -> RegW=1, RegDst=0, Aluctrl=1. Then Funct 001000 -> jump=11, RegW=0. Then Funct 111111 -> all outputs 0.
- Imm16=16'h8001:
  - EXTOp 01 -> Imm32=32'hFFFF8001.
  - EXTOp 00 -> 32'h00008001.
  - OpCode 001111 (lui) -> 32'h80010000.
- OpCode 000101 -> Branch=10, Aluctrl=1. OpCode 000011 -> Branch=11, jump=10, RegW=0.
- Register hold: apply rst at an edge, then load ALU_C_IN=32'hDEADBEEF, reg_rd_in=5'd9, REGW_IN=1 with EX_MEM_WR=1. Next edge, the outputs show these values. Drop EX_MEM_WR and change the inputs; the outputs hold.
- Register reset priority: assert rst together with EX_MEM_WR=1 -> all outputs 0 after the edge. With EXMEM_FLUSH_EN defined, flush=1 zeroes the control fields while ALU_C_OUT still loads.
